alu_iter_seq: RTL and testbench
===============================

// Module: alu_iter_seq
// PURPOSE
//  Iterative operand sequencer sitting directly upstream of the 8-bit ALU (mode 00=A/2+B,
//  01=A-B, 10=A>>1, 11=A<<1). On a start pulse it latches A, B, mode and a repeat count,
//  then feeds the ALU once per cycle, writing ALU result Y back into its accumulator as the
//  next A. After N passes it presents the final value with a one-cycle done strobe.
//  Provides multi-step shift/sub/halve-add chains without external control logic.
// PARAMETERS
//  W      8   datapath width; must match ALU operand width
//  CNT_W  4   repeat-count width; max passes = 2**CNT_W-1
// PORTS
//  clk       in   1      system clock, all state on rising edge
//  rst       in   1      asynchronous, active-high reset
//  start     in   1      request new run; sampled only in IDLE
//  A_in      in   W      initial A operand
//  B_in      in   W      B operand, held constant for whole run
//  mode_in   in   2      ALU mode for whole run
//  count     in   CNT_W  number of ALU passes (0 allowed)
//  alu_A     out  W      to ALU A; equals accumulator register
//  alu_B     out  W      to ALU B; equals latched B
//  alu_mode  out  2      to ALU mode; equals latched mode
//  alu_Y     in   W      combinational result from ALU
//  result    out  W      final value of last run; held until next run completes
//  busy      out  1      high while in EXEC
//  done      out  1      one-cycle strobe, high in DONE
// BEHAVIOUR
//  Reset (async, any state, incl. mid-run): state=IDLE; acc, B_reg, mode_reg, cnt, result=0;
//   busy=0, done=0; alu_A/alu_B/alu_mode=0. Partial run discarded, no done.
//  FSM states IDLE, EXEC, DONE:
//   IDLE: start=1 -> acc<=A_in, B_reg<=B_in, mode_reg<=mode_in, cnt<=count;
//         next=EXEC if count!=0, else DONE. start=0 -> stay.
//   EXEC: each cycle acc<=alu_Y, cnt<=cnt-1; when cnt==1 the same edge also loads
//         result<=alu_Y and goes to DONE. Otherwise stay.
//   DONE: done=1 for exactly this cycle; next=IDLE unconditionally.
//   count==0 run: DONE entered directly; result<=A_in on that same edge (no ALU pass).
//  start is ignored in EXEC and DONE (no queuing); held-high start begins a new run from
//   the first IDLE cycle after DONE. A_in/B_in/mode_in/count changes after the accepting
//   edge have no effect on the run in progress.
//  Latency: start sampled at edge 0; EXEC occupies cycles 1..N; done high in cycle N+1
//   (cycle 1 for N=0). Back-to-back run spacing is N+2 cycles.
//  Arithmetic owned by the ALU; sequencer adds no width growth. acc is W bits, wraps mod 2**W
//   as delivered by the ALU. cnt never underflows (only decremented in EXEC with cnt>=1).
//  alu_* outputs come straight from registers: stable for the full cycle, glitch-free.
//  result changes only on the edge entering DONE or on reset.
// TESTING
//  1 reset mid-EXEC (mode 10, A=0xFF, count=5, rst at cycle 3) -> IDLE, result=0, no done.
//  2 mode 10, A=0x80, count=3 -> alu_A 0x80,0x40,0x20; done in cycle 4; result=0x10.
//  3 mode 01, A=0x05, B=0x03, count=2 -> result=0xFF (wrap), busy high cycles 1-2.
//  4 mode 00, A=0x40, B=0x01, count=2 -> 0x21 then result=0x11.
//  5 count=0, A=0x5A, start -> done in cycle 1, result=0x5A, busy never high.
//  6 start held high, mode 11, A=0x81, count=1 -> result=0x02 each run, done every 3
//    cycles; start pulses during EXEC/DONE ignored.

Source files
------------

// File: rtl/alu_iter_seq.sv
// Iterative operand sequencer for the 8-bit ALU: latches A/B/mode/count on start,
// feeds ALU result back as the next A for count passes, then strobes done with the result.
module alu_iter_seq #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     A_in,
  input  logic [W-1:0]     B_in,
  input  logic [1:0]       mode_in,
  input  logic [CNT_W-1:0] count,
  output logic [W-1:0]     alu_A,
  output logic [W-1:0]     alu_B,
  output logic [1:0]       alu_mode,
  input  logic [W-1:0]     alu_Y,
  output logic [W-1:0]     result,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     b_q, b_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and datapath update; busy/done are decoded from the next state so they are flops.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d  = A_in;
          b_d    = B_in;
          mode_d = mode_in;
          cnt_d  = count;
          if (count != CNT_ZERO) begin
            state_d = S_EXEC;
          end else begin
            // Zero-pass run: the operand itself is the answer.
            state_d  = S_DONE;
            result_d = A_in;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        acc_d = alu_Y;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = alu_Y;
          state_d  = S_DONE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_EXEC);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset discards any partial run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      mode_q   <= 2'b00;
      cnt_q    <= CNT_ZERO;
      result_q <= {W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign alu_A    = acc_q;
  assign alu_B    = b_q;
  assign alu_mode = mode_q;
  assign result   = result_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_iter_seq.sv
// Self-checking bench for alu_iter_seq: directed cases plus randomized runs against a pass-chain model.
module tb_alu_iter_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A_in, B_in;
  logic [1:0] mode_in;
  logic [3:0] count;
  logic [7:0] alu_A, alu_B, alu_Y, result;
  logic [1:0] alu_mode;
  logic       busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  alu_iter_seq #(.W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A_in(A_in), .B_in(B_in), .mode_in(mode_in), .count(count),
    .alu_A(alu_A), .alu_B(alu_B), .alu_mode(alu_mode), .alu_Y(alu_Y),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    case (m)
      2'b00:   return (a >> 1) + b;
      2'b01:   return a - b;
      2'b10:   return a >> 1;
      default: return a << 1;
    endcase
  endfunction

  // The bench plays the role of the downstream combinational ALU.
  always_comb alu_Y = alu_ref(alu_A, alu_B, alu_mode);

  // One complete run from IDLE; optionally scrambles inputs and start while the run is in flight.
  task automatic run_check(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] m, input logic [3:0] n, input bit scramble);
    logic [7:0] acc;
    acc = a;
    A_in = a; B_in = b; mode_in = m; count = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= int'(n); k++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0 || alu_A !== acc || alu_B !== b || alu_mode !== m) begin
        n_fail++;
        $display("FAIL %s exec cycle %0d: busy=%b done=%b alu_A=%h alu_B=%h mode=%b, required busy=1 done=0 alu_A=%h alu_B=%h mode=%b",
                 name, k, busy, done, alu_A, alu_B, alu_mode, acc, b, m);
      end
      acc = alu_ref(acc, b, m);
      if (scramble) begin
        start = 1'($urandom); A_in = 8'($urandom); B_in = 8'($urandom);
        mode_in = 2'($urandom); count = 4'($urandom);
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== acc) begin
      n_fail++;
      $display("FAIL %s done cycle %0d: done=%b busy=%b result=%h, required done=1 busy=0 result=%h",
               name, int'(n) + 1, done, busy, result, acc);
    end
    if (scramble) begin
      start = 1'($urandom); A_in = 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== acc) begin
      n_fail++;
      $display("FAIL %s after done: done=%b busy=%b result=%h, required done=0 busy=0 result=%h",
               name, done, busy, result, acc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A_in = 8'h00; B_in = 8'h00; mode_in = 2'b00; count = 4'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || alu_A !== 8'h00 || alu_B !== 8'h00 || alu_mode !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b result=%h alu_A=%h alu_B=%h mode=%b, required all zero",
               busy, done, result, alu_A, alu_B, alu_mode);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    run_check("warmup_shl", 8'h03, 8'h00, 2'b11, 4'd1, 1'b0);
    A_in = 8'hFF; B_in = 8'h00; mode_in = 2'b10; count = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || alu_A !== 8'h3F) begin
      n_fail++;
      $display("FAIL mid_exec_pre_reset: busy=%b alu_A=%h, required busy=1 alu_A=3f", busy, alu_A);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || alu_A !== 8'h00 || alu_B !== 8'h00 || alu_mode !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_exec_reset: busy=%b done=%b result=%h alu_A=%h alu_B=%h mode=%b, required all zero",
               busy, done, result, alu_A, alu_B, alu_mode);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== 8'h00) begin
        n_fail++;
        $display("FAIL mid_exec_after_reset c%0d: done=%b busy=%b result=%h, required 0 0 00", c, done, busy, result);
      end
    end
  endtask

  task automatic test_directed();
    run_check("halve_chain", 8'h80, 8'h00, 2'b10, 4'd3, 1'b0);
    run_check("sub_wrap",    8'h05, 8'h03, 2'b01, 4'd2, 1'b0);
    run_check("halve_add",   8'h40, 8'h01, 2'b00, 4'd2, 1'b0);
    run_check("count_zero",  8'h5A, 8'h77, 2'b01, 4'd0, 1'b0);
    run_check("max_count",   8'h01, 8'h00, 2'b11, 4'd15, 1'b0);
  endtask

  task automatic test_back_to_back();
    A_in = 8'h81; B_in = 8'h00; mode_in = 2'b11; count = 4'd1; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== (c % 3 == 1) || done !== (c % 3 == 2) ||
          (c % 3 == 1 && alu_A !== 8'h81) || (c % 3 == 2 && result !== 8'h02)) begin
        n_fail++;
        $display("FAIL back_to_back c%0d: busy=%b done=%b alu_A=%h result=%h, required busy=%b done=%b",
                 c, busy, done, alu_A, result, (c % 3 == 1), (c % 3 == 2));
      end
    end
    start = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 25; r++) begin
      run_check("random", 8'($urandom), 8'($urandom), 2'($urandom), 4'($urandom_range(0, 15)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_exec();
    test_directed();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
